// File: rtl/mpc_h_pkg.sv
// ============================================================================
// mpc_h_pkg : shared types and default sizes for the h-vector RAM reader
// Revision  : 1.0
// ============================================================================
`default_nettype none

package mpc_h_pkg;

   localparam int H_DW    = 21;
   localparam int H_AW    = 5;
   localparam int H_DEPTH = 18;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } h_rd_state_t;

endpackage

`default_nettype wire

// File: rtl/mpc_h_vec_out_stage.sv
// ============================================================================
// mpc_h_vec_out_stage : output register of the reader (S2) with valid/ready hold
// Revision            : 1.0
// ============================================================================
`default_nettype none

module mpc_h_vec_out_stage #(
   parameter int WIDTH = 21
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_data,
   output logic             o_valid
);

   logic [WIDTH-1:0] r_data;
   logic             r_valid;

   // The caller only asserts i_load when the register is empty or draining,
   // so a held beat is never overwritten.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_data  <= '0;
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_data  <= i_data;
         r_valid <= 1'b1;
      end else if (i_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign o_data  = r_data;
   assign o_valid = r_valid;

endmodule

`default_nettype wire

// File: rtl/mpc_h_vec_reader.sv
// ============================================================================
// mpc_h_vec_reader : circular burst reader of the h-vector RAM onto a stream
// Revision         : 1.0
// ============================================================================
`default_nettype none

module mpc_h_vec_reader
   import mpc_h_pkg::*;
#(
   parameter int DataWidth    = H_DW,
   parameter int AddressWidth = H_AW,
   parameter int AddressRange = H_DEPTH
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [AddressWidth-1:0] base,
   input  logic [AddressWidth:0]   len,
   output logic [AddressWidth-1:0] address1,
   output logic                    ce1,
   input  logic [DataWidth-1:0]    q1,
   output logic [DataWidth-1:0]    m_tdata,
   output logic                    m_tvalid,
   input  logic                    m_tready,
   output logic                    m_tlast,
   output logic                    busy,
   output logic                    done,
   output logic                    err
);

   localparam logic [AddressWidth:0]   c_RANGE     = (AddressWidth+1)'(AddressRange);
   localparam logic [AddressWidth-1:0] c_LAST_ADDR = AddressWidth'(AddressRange - 1);
   localparam logic [AddressWidth:0]   c_ONE       = (AddressWidth+1)'(1);

   h_rd_state_t             r_state, w_state_nxt;
   logic [AddressWidth:0]   r_len, r_issued, r_sent;
   logic [AddressWidth-1:0] r_addr;
   logic                    r_s1v, r_done, r_err;

   logic w_cmd_ok, w_accept, w_reject;
   logic w_hs, w_move, w_reads_left, w_ce1, w_last_hs;

   assign w_cmd_ok     = (len != '0) && (len <= c_RANGE) && ({1'b0, base} < c_RANGE);
   assign w_accept     = (r_state == IDLE) && start && w_cmd_ok;
   assign w_reject     = (r_state == IDLE) && start && !w_cmd_ok;

   assign w_hs         = m_tvalid & m_tready;
   assign w_move       = r_s1v & (!m_tvalid | m_tready);
   assign w_reads_left = (r_issued != r_len);
   assign w_ce1        = (r_state == RUN) & w_reads_left & (!r_s1v | w_move);
   assign w_last_hs    = w_hs & (r_sent == r_len - c_ONE);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_state_nxt = RUN;
         RUN:     if (w_ce1 && (r_issued + c_ONE == r_len)) w_state_nxt = DRAIN;
         DRAIN:   if (w_last_hs) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= IDLE;
         r_len    <= '0;
         r_issued <= '0;
         r_sent   <= '0;
         r_addr   <= '0;
         r_s1v    <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_done  <= (r_state == DRAIN) && w_last_hs;
         r_err   <= w_reject;
         r_s1v   <= w_ce1 | (r_s1v & !w_move);
         if (w_accept) begin
            r_len    <= len;
            r_addr   <= base;
            r_issued <= '0;
            r_sent   <= '0;
         end else begin
            // Wrapping increment keeps the address in range without a modulo.
            if (w_ce1) begin
               r_issued <= r_issued + c_ONE;
               r_addr   <= (r_addr == c_LAST_ADDR) ? '0 : r_addr + 1'b1;
            end
            if (w_hs) r_sent <= r_sent + c_ONE;
         end
      end
   end

   mpc_h_vec_out_stage #(
      .WIDTH (DataWidth)
   ) u_out_stage (
      .clk     (clk),
      .rst     (reset),
      .i_load  (w_move),
      .i_data  (q1),
      .i_ready (m_tready),
      .o_data  (m_tdata),
      .o_valid (m_tvalid)
   );

   assign address1 = r_addr;
   assign ce1      = w_ce1;
   assign m_tlast  = m_tvalid & (r_sent == r_len - c_ONE);
   assign busy     = (r_state != IDLE);
   assign done     = r_done;
   assign err      = r_err;

endmodule

`default_nettype wire

// File: tb/tb_mpc_h_vec_reader.sv
// ============================================================================
// tb_mpc_h_vec_reader : randomized bench against a queue-based burst model
// Revision            : 1.0
// ============================================================================
`default_nettype none

module tb_mpc_h_vec_reader;
   import mpc_h_pkg::*;

   localparam int DW    = H_DW;
   localparam int AW    = H_AW;
   localparam int DEPTH = H_DEPTH;

   logic          clk = 1'b0;
   logic          reset, start, m_tready;
   logic [AW-1:0] base;
   logic [AW:0]   len;
   logic [DW-1:0] q1;
   logic [AW-1:0] address1;
   logic          ce1, m_tvalid, m_tlast, busy, done, err;
   logic [DW-1:0] m_tdata;

   logic [DW-1:0] mem [0:31];
   int            n_tests = 0;
   int            n_fail  = 0;

   always #5 clk = ~clk;

   always @(posedge clk) if (ce1) q1 <= mem[address1];

   mpc_h_vec_reader dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .base     (base),
      .len      (len),
      .address1 (address1),
      .ce1      (ce1),
      .q1       (q1),
      .m_tdata  (m_tdata),
      .m_tvalid (m_tvalid),
      .m_tready (m_tready),
      .m_tlast  (m_tlast),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] all_outs();
      return {ce1, address1, m_tvalid, m_tdata, m_tlast, busy, done, err};
   endfunction

   // mode 0: always ready, 1: stall cycles 4..9 then random, 2: random
   task automatic burst(input int b, input int l, input int mode, input bit ideal,
                        input bit extra_start, input int rst_at);
      logic [DW-1:0] exp_q[$];
      logic [DW-1:0] pdata;
      logic          plast;
      int  n_iss = 0, n_hs = 0;
      bit  got_done = 0, stall_prev = 0;
      for (int i = 0; i < l; i++) exp_q.push_back(mem[(b + i) % DEPTH]);
      @(negedge clk);
      start = 1'b1; base = AW'(b); len = (AW+1)'(l); m_tready = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int cyc = 1; cyc <= 200 && !got_done; cyc++) begin
         @(negedge clk);
         case (mode)
            0:       m_tready = 1'b1;
            1:       m_tready = (cyc < 4) ? 1'b1 : (cyc <= 9) ? 1'b0 : 1'($urandom_range(0, 1));
            default: m_tready = 1'($urandom_range(0, 1));
         endcase
         if (extra_start) begin
            start = (cyc == 5);
            if (cyc == 5) begin
               base = AW'($urandom_range(0, DEPTH - 1));
               len  = (AW+1)'($urandom_range(1, DEPTH));
            end
         end
         if (rst_at >= 0 && n_hs == rst_at) begin
            reset = 1'b1;
            @(negedge clk);
            #1 check("reset_mid_outs", all_outs(), 32'd0);
            reset = 1'b0;
            repeat (3) begin
               @(negedge clk);
               #1 check("reset_mid_no_done", {31'd0, done}, 32'd0);
            end
            return;
         end
         #1;
         if (cyc == 1) check("busy_rise", {31'd0, busy}, 32'd1);
         if (ce1) begin
            check("address", {27'd0, address1}, 32'((b + n_iss) % DEPTH));
            if (ideal) check("ce1_cycle", 32'(cyc), 32'(n_iss + 1));
            n_iss++;
         end
         if (stall_prev)
            check("stall_hold", {m_tvalid, m_tlast, m_tdata}, {1'b1, plast, pdata});
         if (m_tvalid) check("tlast", {31'd0, m_tlast}, {31'd0, n_hs == l - 1});
         if (m_tvalid && m_tready) begin
            check("data", {11'd0, m_tdata}, (n_hs < l) ? {11'd0, exp_q[n_hs]} : 32'hFFFF_FFFF);
            if (ideal) check("beat_cycle", 32'(cyc), 32'(n_hs + 3));
            n_hs++;
         end
         if (ce1) check("inflight", {31'd0, (n_iss - n_hs) <= 2}, 32'd1);
         stall_prev = m_tvalid && !m_tready;
         pdata      = m_tdata;
         plast      = m_tlast;
         if (done) begin
            got_done = 1;
            check("done_beats", 32'(n_hs), 32'(l));
            check("busy_fall", {31'd0, busy}, 32'd0);
            if (ideal) check("done_cycle", 32'(cyc), 32'(l + 3));
         end
      end
      start = 1'b0;
      check("done_seen", {31'd0, got_done}, 32'd1);
      check("issued", 32'(n_iss), 32'(l));
   endtask

   task automatic bad_cmd(input int b, input int l);
      @(negedge clk);
      start = 1'b1; base = AW'(b); len = (AW+1)'(l); m_tready = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      #1 check("err_pulse", {29'd0, err, ce1, busy}, 32'b100);
      @(negedge clk);
      #1 check("err_after", {29'd0, err, ce1, busy}, 32'b000);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; base = '0; len = '0; m_tready = 1'b1;
      for (int i = 0; i < 32; i++) mem[i] = DW'($urandom);
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1 check("reset_outs", all_outs(), 32'd0);
      reset = 1'b0;

      burst(0, 18, 0, 1, 0, -1);
      burst(15, 6, 0, 1, 0, -1);
      burst(17, 1, 0, 1, 0, -1);
      burst(3, 10, 1, 0, 0, -1);
      bad_cmd(0, 0);
      bad_cmd(0, 19);
      bad_cmd(18, 5);
      burst(7, 18, 0, 1, 1, -1);
      burst(0, 18, 0, 0, 0, 5);
      burst(2, 3, 0, 1, 0, -1);
      for (int k = 0; k < 20; k++)
         burst($urandom_range(0, DEPTH - 1), $urandom_range(1, DEPTH), 2, 0, 0, -1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
